syn_gpu_div_q: RTL and testbench



---
 rtl/syn_gpu_pkg.sv | 27 ++
 rtl/syn_gpu_div_core.sv | 153 +++++++++++++++
 rtl/syn_gpu_div_q.sv | 123 ++++++++++++
 tb/tb_syn_gpu_div_q.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/syn_gpu_pkg.sv
// Shared types and constants for the queued GPU divider (syn_gpu_div_q).
package syn_gpu_pkg;

    localparam int P_DIV_W_DEF = 16;
    localparam int P_MID_W_DEF = 4;

    // MID value reserved to mean "no response present"
    localparam int MID_IDLE    = 0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        RSP  = 3'd4
    } div_fsm_t;

    // Request FIFO word at the default widths; the top declares the same
    // layout sized by its own parameters.
    typedef struct packed {
        logic [P_MID_W_DEF-1:0] mid;
        logic [P_DIV_W_DEF-1:0] dividend;
        logic [P_DIV_W_DEF-1:0] divisor;
        logic                   sgn;
    } div_req_t;

endpackage

// File: rtl/syn_gpu_div_core.sv
// Radix-2 restoring divide engine (LOAD/CALC/FIX) with start/done handshake.
// SYN_GPU_DIV_SIGNED_EN builds the operand-magnitude and result-negate logic;
// without it every request is treated as unsigned and FIX is a plain pass-through.
module syn_gpu_div_core
    import syn_gpu_pkg::*;
#(
    parameter int P_DATA_W = P_DIV_W_DEF
) (
    input  logic                clk_ir,
    input  logic                rst_sync_l,
    input  logic                start_i,
    input  logic                sgn_i,
    input  logic [P_DATA_W-1:0] dividend_i,
    input  logic [P_DATA_W-1:0] divisor_i,
    output logic                idle_o,
    output logic                done_o,
    output logic [P_DATA_W-1:0] quo_o,
    output logic [P_DATA_W-1:0] rem_o,
    output logic                dbz_o
);

    localparam int CW = $clog2(P_DATA_W);

    div_fsm_t            state_q, state_d;
    logic [P_DATA_W-1:0] n_q, n_d;      // dividend shifting out, quotient shifting in
    logic [P_DATA_W-1:0] d_q, d_d;      // divisor magnitude
    logic [P_DATA_W-1:0] r_q, r_d;      // partial remainder
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                dbz_q, dbz_d;
    logic [P_DATA_W:0]   pr;
    logic [P_DATA_W+1:0] trial;

    // Partial remainder with the next dividend bit; extra top bit of trial is the borrow
    assign pr    = {r_q, n_q[P_DATA_W-1]};
    assign trial = {1'b0, pr} - {2'b00, d_q};

`ifdef SYN_GPU_DIV_SIGNED_EN
    logic sgn_q, sgn_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic s_n, s_d;
    assign s_n = sgn_q & n_q[P_DATA_W-1];
    assign s_d = sgn_q & d_q[P_DATA_W-1];
`else
    logic unused_sgn;
    assign unused_sgn = sgn_i;
`endif

    // Next-state and datapath update for each engine phase
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
`ifdef SYN_GPU_DIV_SIGNED_EN
        sgn_d     = sgn_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    n_d     = dividend_i;
                    d_d     = divisor_i;
`ifdef SYN_GPU_DIV_SIGNED_EN
                    sgn_d   = sgn_i;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                r_d   = '0;
                cnt_d = CW'(P_DATA_W - 1);
                dbz_d = (d_q == '0);
                // On divide-by-zero n_q keeps the raw dividend for the remainder
                if (d_q == '0) begin
                    state_d = FIX;
                end else begin
`ifdef SYN_GPU_DIV_SIGNED_EN
                    neg_quo_d = s_n ^ s_d;
                    neg_rem_d = s_n;
                    if (s_n) n_d = -n_q;
                    if (s_d) d_d = -d_q;
`endif
                    state_d = CALC;
                end
            end
            CALC: begin
                if (!trial[P_DATA_W+1]) begin
                    r_d = trial[P_DATA_W-1:0];
                    n_d = {n_q[P_DATA_W-2:0], 1'b1};
                end else begin
                    r_d = pr[P_DATA_W-1:0];
                    n_d = {n_q[P_DATA_W-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Engine state registers
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            state_q <= IDLE;
            n_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef SYN_GPU_DIV_SIGNED_EN
            sgn_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
`ifdef SYN_GPU_DIV_SIGNED_EN
            sgn_q     <= sgn_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    // Result fix-up presented while in FIX
    always_comb begin
        quo_o = n_q;
        rem_o = r_q;
        if (dbz_q) begin
            quo_o = '1;
            rem_o = n_q;
        end
`ifdef SYN_GPU_DIV_SIGNED_EN
        else begin
            if (neg_quo_q) quo_o = -n_q;
            if (neg_rem_q) rem_o = -r_q;
        end
`endif
    end

    assign idle_o = (state_q == IDLE);
    assign done_o = (state_q == FIX);
    assign dbz_o  = dbz_q;

endmodule

// File: rtl/syn_gpu_div_q.sv
// Queued, tagged divider: request FIFO -> divide engine -> response register.
// Optional signed mode is built when SYN_GPU_DIV_SIGNED_EN is defined.
module syn_gpu_div_q
    import syn_gpu_pkg::*;
#(
    parameter int P_DATA_W    = P_DIV_W_DEF,
    parameter int P_MID_W     = P_MID_W_DEF,
    parameter int P_REQ_DEPTH = 4
) (
    input  logic                clk_ir,
    input  logic                rst_sync_l,
    input  logic                req_valid,
    output logic                req_rdy,
    input  logic [P_MID_W-1:0]  req_mid,
    input  logic [P_DATA_W-1:0] req_dividend,
    input  logic [P_DATA_W-1:0] req_divisor,
    input  logic                req_signed,
    output logic                rsp_valid,
    input  logic                rsp_rdy,
    output logic [P_MID_W-1:0]  rsp_mid,
    output logic [P_DATA_W-1:0] rsp_quo,
    output logic [P_DATA_W-1:0] rsp_rem,
    output logic                rsp_dbz,
    output logic                busy
);

    localparam int AW = $clog2(P_REQ_DEPTH);

    typedef struct packed {
        logic [P_MID_W-1:0]  mid;
        logic [P_DATA_W-1:0] dividend;
        logic [P_DATA_W-1:0] divisor;
        logic                sgn;
    } req_t;

    req_t                mem_q [P_REQ_DEPTH];
    req_t                head;
    logic [AW:0]         wr_ptr_q, rd_ptr_q;
    logic                full, empty, push, pop;

    logic [P_MID_W-1:0]  cur_mid_q;
    logic                rsp_valid_q, rsp_dbz_q;
    logic [P_MID_W-1:0]  rsp_mid_q;
    logic [P_DATA_W-1:0] rsp_quo_q, rsp_rem_q;

    logic                core_idle, core_done, core_dbz;
    logic [P_DATA_W-1:0] core_quo, core_rem;

    // Pointers carry one wrap bit so full and empty are distinguishable
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = req_valid & ~full;
    // A new request starts only once the previous response has been taken
    assign pop   = ~empty & core_idle & ~rsp_valid_q;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // FIFO storage; data needs no reset since the pointers gate it
    always_ff @(posedge clk_ir) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{mid: req_mid, dividend: req_dividend,
                                               divisor: req_divisor, sgn: req_signed};
    end

    // FIFO pointers and the tag of the request in flight
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cur_mid_q <= P_MID_W'(MID_IDLE);
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                cur_mid_q <= head.mid;
            end
        end
    end

    syn_gpu_div_core #(
        .P_DATA_W (P_DATA_W)
    ) u_core (
        .clk_ir     (clk_ir),
        .rst_sync_l (rst_sync_l),
        .start_i    (pop),
        .sgn_i      (head.sgn),
        .dividend_i (head.dividend),
        .divisor_i  (head.divisor),
        .idle_o     (core_idle),
        .done_o     (core_done),
        .quo_o      (core_quo),
        .rem_o      (core_rem),
        .dbz_o      (core_dbz)
    );

    // Response register: captured on engine done, held until the consumer accepts
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            rsp_valid_q <= 1'b0;
            rsp_mid_q   <= P_MID_W'(MID_IDLE);
            rsp_quo_q   <= '0;
            rsp_rem_q   <= '0;
            rsp_dbz_q   <= 1'b0;
        end else if (core_done) begin
            rsp_valid_q <= 1'b1;
            rsp_mid_q   <= cur_mid_q;
            rsp_quo_q   <= core_quo;
            rsp_rem_q   <= core_rem;
            rsp_dbz_q   <= core_dbz;
        end else if (rsp_valid_q && rsp_rdy) begin
            rsp_valid_q <= 1'b0;
            rsp_mid_q   <= P_MID_W'(MID_IDLE);
        end
    end

    assign req_rdy   = ~full;
    assign rsp_valid = rsp_valid_q;
    assign rsp_mid   = rsp_mid_q;
    assign rsp_quo   = rsp_quo_q;
    assign rsp_rem   = rsp_rem_q;
    assign rsp_dbz   = rsp_dbz_q;
    assign busy      = ~empty | ~core_idle | rsp_valid_q;

endmodule

// File: tb/tb_syn_gpu_div_q.sv
// Directed self-checking bench for syn_gpu_div_q (16b data, 4b MID, depth 4).
module tb_syn_gpu_div_q;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_rdy, req_signed;
    logic [3:0]  req_mid;
    logic [15:0] req_dividend, req_divisor;
    logic        rsp_valid, rsp_rdy, rsp_dbz, busy;
    logic [3:0]  rsp_mid;
    logic [15:0] rsp_quo, rsp_rem;

    int n_chk = 0;
    int n_fail = 0;

    // burst vectors: mid, N, D, quo, rem, dbz
    logic [3:0]  bm [5] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    logic [15:0] bn [5] = '{16'd50000, 16'd12345, 16'd65535, 16'd9, 16'd40000};
    logic [15:0] bd [5] = '{16'd300, 16'd123, 16'd256, 16'd0, 16'd3};
    logic [15:0] bq [5] = '{16'd166, 16'd100, 16'd255, 16'hFFFF, 16'd13333};
    logic [15:0] br [5] = '{16'd200, 16'd45, 16'd255, 16'd9, 16'd1};
    logic        bz [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    syn_gpu_div_q #(
        .P_DATA_W    (16),
        .P_MID_W     (4),
        .P_REQ_DEPTH (4)
    ) dut (
        .clk_ir       (clk),
        .rst_sync_l   (rst_n),
        .req_valid    (req_valid),
        .req_rdy      (req_rdy),
        .req_mid      (req_mid),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_signed   (req_signed),
        .rsp_valid    (rsp_valid),
        .rsp_rdy      (rsp_rdy),
        .rsp_mid      (rsp_mid),
        .rsp_quo      (rsp_quo),
        .rsp_rem      (rsp_rem),
        .rsp_dbz      (rsp_dbz),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] mid, input logic [15:0] n, input logic [15:0] d,
                        input logic s);
        req_mid      = mid;
        req_dividend = n;
        req_divisor  = d;
        req_signed   = s;
        req_valid    = 1'b1;
        tick();
        req_valid    = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("rsp_seen", rsp_valid, 1'b1);
    endtask

    task automatic chk_rsp(input string tag, input logic [3:0] mid, input logic [15:0] q,
                           input logic [15:0] r, input logic z);
        chk({tag, "_mid"}, rsp_mid, mid);
        chk({tag, "_quo"}, rsp_quo, q);
        chk({tag, "_rem"}, rsp_rem, r);
        chk({tag, "_dbz"}, rsp_dbz, z);
    endtask

    // one isolated request: latency, result, then acknowledge
    task automatic run1(input string tag, input logic [3:0] mid, input logic [15:0] n,
                        input logic [15:0] d, input logic s, input logic [15:0] q,
                        input logic [15:0] r, input logic z, input int lat);
        int cyc;
        send(mid, n, d, s);
        wait_rsp(cyc);
        chk({tag, "_lat"}, 64'(cyc), 64'(lat));
        chk_rsp(tag, mid, q, r, z);
        tick();
        chk({tag, "_ack_vld"}, rsp_valid, 1'b0);
        chk({tag, "_ack_mid"}, rsp_mid, 4'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_rdy"}, req_rdy, 1'b1);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_rsp_mid"}, rsp_mid, 4'd0);
        chk({tag, "_rsp_quo"}, rsp_quo, 16'd0);
        chk({tag, "_rsp_rem"}, rsp_rem, 16'd0);
        chk({tag, "_rsp_dbz"}, rsp_dbz, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic seen_vld, seen_busy;
        rst_n = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_mid = '0;
        req_dividend = '0; req_divisor = '0; rsp_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();

        // isolated requests
        run1("u1000_7",  4'd3, 16'd1000,  16'd7,      1'b0, 16'd142,   16'd6,      1'b0, 19);
        run1("dbz",      4'd5, 16'h1234,  16'h0000,   1'b0, 16'hFFFF,  16'h1234,   1'b1, 3);
        run1("uffff_1",  4'd1, 16'hFFFF,  16'd1,      1'b0, 16'hFFFF,  16'd0,      1'b0, 19);
        run1("u5_9",     4'd2, 16'd5,     16'd9,      1'b0, 16'd0,     16'd5,      1'b0, 19);
        run1("uffff_ff", 4'd4, 16'hFFFF,  16'hFFFF,   1'b0, 16'd1,     16'd0,      1'b0, 19);
`ifdef SYN_GPU_DIV_SIGNED_EN
        run1("s_m7_2",   4'd6, 16'hFFF9,  16'd2,      1'b1, 16'hFFFD,  16'hFFFF,   1'b0, 19);
        run1("s_min_m1", 4'd7, 16'h8000,  16'hFFFF,   1'b1, 16'h8000,  16'd0,      1'b0, 19);
        run1("s_7_m2",   4'd8, 16'd7,     16'hFFFE,   1'b1, 16'hFFFD,  16'd1,      1'b0, 19);
        run1("s_m8_m3",  4'd10, 16'hFFF8, 16'hFFFD,   1'b1, 16'd2,     16'hFFFE,   1'b0, 19);
`else
        run1("s_m7_2",   4'd6, 16'hFFF9,  16'd2,      1'b1, 16'h7FFC,  16'd1,      1'b0, 19);
        run1("s_min_m1", 4'd7, 16'h8000,  16'hFFFF,   1'b1, 16'd0,     16'h8000,   1'b0, 19);
        run1("s_7_m2",   4'd8, 16'd7,     16'hFFFE,   1'b1, 16'd0,     16'd7,      1'b0, 19);
        run1("s_m8_m3",  4'd10, 16'hFFF8, 16'hFFFD,   1'b1, 16'd0,     16'hFFF8,   1'b0, 19);
`endif
        run1("s_dbz",    4'd9, 16'hFFF9,  16'd0,      1'b1, 16'hFFFF,  16'hFFF9,   1'b1, 3);

        // burst of 5 behind a response held by backpressure
        rsp_rdy = 1'b0;
        send(4'd1, 16'd100, 16'd10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("burst_rdy", req_rdy, 1'b1);
            send(bm[i], bn[i], bd[i], 1'b0);
        end
        chk("full_rdy", req_rdy, 1'b0);
        req_mid = bm[4]; req_dividend = bn[4]; req_divisor = bd[4]; req_signed = 1'b0;
        req_valid = 1'b1;
        wait_rsp(cyc);
        chk("bp_lat", 64'(cyc), 64'd15);
        chk_rsp("bpA", 4'd1, 16'd10, 16'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_stable", {rsp_valid, rsp_mid, rsp_quo, rsp_rem, rsp_dbz},
                {1'b1, 4'd1, 16'd10, 16'd0, 1'b0});
            chk("bp_busy", busy, 1'b1);
            chk("bp_nopop", req_rdy, 1'b0);
        end
        rsp_rdy = 1'b1;
        tick();
        chk("rel_vld", rsp_valid, 1'b0);
        chk("rel_mid", rsp_mid, 4'd0);
        chk("rel_full", req_rdy, 1'b0);
        tick();
        chk("pop_rdy", req_rdy, 1'b1);
        tick();
        req_valid = 1'b0;
        chk("refill_rdy", req_rdy, 1'b0);
        for (int i = 0; i < 5; i++) begin
            wait_rsp(cyc);
            chk_rsp("burst", bm[i], bq[i], br[i], bz[i]);
            tick();
        end
        tick();
        chk("drain_busy", busy, 1'b0);

        // reset in the middle of CALC with two requests queued
        send(4'd7, 16'd1000, 16'd7, 1'b0);
        send(4'd8, 16'd2000, 16'd7, 1'b0);
        send(4'd9, 16'd3000, 16'd7, 1'b0);
        repeat (5) tick();
        chk("pre_rst_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        seen_vld = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen_vld  = seen_vld | rsp_valid;
            seen_busy = seen_busy | busy;
        end
        chk("no_stale_rsp", seen_vld, 1'b0);
        chk("no_stale_busy", seen_busy, 1'b0);

        // engine still usable after the reset
        run1("post_rst", 4'd11, 16'd1000, 16'd7, 1'b0, 16'd142, 16'd6, 1'b0, 19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
